// File: rtl/wire_arith_engine.sv
// Host-wire arithmetic engine: ADD/SUB in one cycle, 32x32 unsigned multiply by
// 32-step shift-add; results and status are exposed as wire-outs.
module wire_arith_engine #(
  parameter int COUNT_W = 8
) (
  input  logic        ti_clk,
  input  logic        reset,
  input  logic [31:0] ep_ctrl,
  input  logic [31:0] ep_op_a,
  input  logic [31:0] ep_op_b,
  output logic [31:0] ep_result_lo,
  output logic [31:0] ep_result_hi,
  output logic [31:0] ep_status,
  output logic [7:0]  led_state
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t       state_reg, state_next;
  logic         start_q_reg;
  logic         start_edge, accept, complete;
  logic [1:0]   op_reg;
  logic [31:0]  a_reg, b_reg;
  logic [63:0]  acc_reg, mcand_reg, acc_sum;
  logic [4:0]   iter_reg;
  logic [32:0]  add_full;
  logic [63:0]  res_next;
  logic         flag_next, err_next;
  logic         busy_reg, done_reg, flag_reg, err_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [31:0]  lo_reg, hi_reg;
  logic [5:0]   count_led;
  logic         unused_ctrl;

  assign unused_ctrl = ^ep_ctrl[31:4];
  assign start_edge  = ep_ctrl[0] & ~start_q_reg;

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          accept     = 1'b1;
          state_next = (ep_ctrl[2:1] == 2'b10) ? MUL : EXEC;
        end
      end
      EXEC: begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      MUL: begin
        if (iter_reg == 5'd31) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // b_reg doubles as the multiplier shift register while in MUL
  assign acc_sum  = b_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign add_full = {1'b0, a_reg} + {1'b0, b_reg};

  always_comb begin
    res_next  = 64'h0;
    flag_next = 1'b0;
    err_next  = 1'b0;
    if (state_reg == MUL) begin
      res_next  = acc_sum;
      flag_next = |acc_sum[63:32];
    end else begin
      case (op_reg)
        2'b00: begin
          res_next  = {32'h0, add_full[31:0]};
          flag_next = add_full[32];
        end
        2'b01: begin
          res_next  = {32'h0, a_reg - b_reg};
          flag_next = a_reg < b_reg;
        end
        2'b11:   err_next = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      start_q_reg <= 1'b1;
      op_reg      <= 2'b00;
      a_reg       <= 32'h0;
      b_reg       <= 32'h0;
      acc_reg     <= 64'h0;
      mcand_reg   <= 64'h0;
      iter_reg    <= 5'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      flag_reg    <= 1'b0;
      err_reg     <= 1'b0;
      count_reg   <= '0;
      lo_reg      <= 32'h0;
      hi_reg      <= 32'h0;
    end else begin
      start_q_reg <= ep_ctrl[0];
      if (accept) begin
        a_reg     <= ep_op_a;
        b_reg     <= ep_op_b;
        op_reg    <= ep_ctrl[2:1];
        acc_reg   <= 64'h0;
        mcand_reg <= {32'h0, ep_op_a};
        iter_reg  <= 5'd0;
        busy_reg  <= 1'b1;
        done_reg  <= 1'b0;
        flag_reg  <= 1'b0;
        err_reg   <= 1'b0;
      end else if (state_reg == MUL) begin
        acc_reg   <= acc_sum;
        mcand_reg <= mcand_reg << 1;
        b_reg     <= b_reg >> 1;
        iter_reg  <= iter_reg + 5'd1;
      end
      // completion takes priority over a same-cycle clear
      if (complete) begin
        lo_reg    <= res_next[31:0];
        hi_reg    <= res_next[63:32];
        flag_reg  <= flag_next;
        err_reg   <= err_next;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b1;
        count_reg <= count_reg + COUNT_W'(1);
      end else if (!accept && ep_ctrl[3]) begin
        done_reg  <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_led
      if (gi < COUNT_W) begin : g_bit
        assign count_led[gi] = count_reg[gi];
      end else begin : g_pad
        assign count_led[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    ep_status              = 32'h0;
    ep_status[3:0]         = {err_reg, flag_reg, done_reg, busy_reg};
    ep_status[8 +: COUNT_W] = count_reg;
  end

  assign ep_result_lo = lo_reg;
  assign ep_result_hi = hi_reg;
  assign led_state    = {count_led, done_reg, busy_reg};

endmodule

// File: tb/tb_wire_arith_engine.sv
// Self-checking bench for wire_arith_engine: vector table plus scoreboard queue,
// with hand-written sequences for re-trigger, clear, reset and count wrap.
module tb_wire_arith_engine;

  logic        ti_clk = 1'b0;
  logic        reset;
  logic [31:0] ep_ctrl, ep_op_a, ep_op_b;
  logic [31:0] ep_result_lo, ep_result_hi, ep_status;
  logic [7:0]  led_state;

  always #5 ti_clk = ~ti_clk;

  wire_arith_engine #(.COUNT_W(8)) dut (
    .ti_clk      (ti_clk),
    .reset       (reset),
    .ep_ctrl     (ep_ctrl),
    .ep_op_a     (ep_op_a),
    .ep_op_b     (ep_op_b),
    .ep_result_lo(ep_result_lo),
    .ep_result_hi(ep_result_hi),
    .ep_status   (ep_status),
    .led_state   (led_state)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, lo, hi;
    logic        flag, err;
  } vec_t;

  vec_t       vecs[16];
  vec_t       sb_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] exp_count = 8'd0;

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic flag, input logic err);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.flag = flag; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   busy_cnt;
    int   guard;
    vec_t e;
    sb_q.push_back(v);
    @(negedge ti_clk);
    ep_ctrl = {28'h0, 1'b0, v.op, 1'b0};
    ep_op_a = v.a;
    ep_op_b = v.b;
    @(negedge ti_clk);
    ep_ctrl[0] = 1'b1;
    @(negedge ti_clk);
    chk("busy_after_start", 64'(ep_status[1:0]), 64'(2'b01));
    ep_op_a = $urandom;
    ep_op_b = $urandom;
    busy_cnt = 0;
    guard    = 0;
    while (!ep_status[1] && guard < 64) begin
      if (ep_status[0]) busy_cnt++;
      @(negedge ti_clk);
      guard++;
    end
    exp_count = exp_count + 8'd1;
    e = sb_q.pop_front();
    chk("done",        64'(ep_status[1]), 64'(1'b1));
    chk("busy_end",    64'(ep_status[0]), 64'(1'b0));
    chk("busy_cycles", 64'(busy_cnt),     (e.op == 2'b10) ? 64'(32) : 64'(1));
    chk("result",      {ep_result_hi, ep_result_lo}, {e.hi, e.lo});
    chk("flag",        64'(ep_status[2]), 64'(e.flag));
    chk("err",         64'(ep_status[3]), 64'(e.err));
    chk("count",       64'(ep_status[15:8]), 64'(exp_count));
    chk("led",         64'(led_state), 64'({exp_count[5:0], 2'b10}));
    n_vec++;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h status=%h led=%h",
             e.op, e.a, e.b, ep_result_hi, ep_result_lo, ep_status, led_state);
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    while (!ep_status[1] && guard < 64) begin
      @(negedge ti_clk);
      guard++;
    end
    chk(name, 64'(ep_status[1]), 64'(1'b1));
  endtask

  initial begin
    logic        seen_busy;
    logic [31:0] ra, rb;
    logic [63:0] prod;
    logic [32:0] sum;

    vecs[0] = mk(2'b00, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1'b1, 1'b0);
    vecs[1] = mk(2'b01, 32'h5,         32'h7,         32'h0,         32'hFFFF_FFFE, 1'b1, 1'b0);
    vecs[2] = mk(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         1'b1, 1'b0);
    vecs[3] = mk(2'b00, 32'h1234_5678, 32'h1111_1111, 32'h0,         32'h2345_6789, 1'b0, 1'b0);
    vecs[4] = mk(2'b01, 32'd10,        32'd3,         32'h0,         32'd7,         1'b0, 1'b0);
    vecs[5] = mk(2'b10, 32'd3,         32'd5,         32'h0,         32'd15,        1'b0, 1'b0);
    vecs[6] = mk(2'b10, 32'h1_0000,    32'h1_0000,    32'h1,         32'h0,         1'b1, 1'b0);
    vecs[7] = mk(2'b11, 32'd5,         32'd6,         32'h0,         32'h0,         1'b0, 1'b1);
    vecs[8] = mk(2'b01, 32'd7,         32'd7,         32'h0,         32'h0,         1'b0, 1'b0);
    vecs[9] = mk(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h0,         1'b1, 1'b0);
    vecs[10] = mk(2'b10, 32'h0,        32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0, 1'b0);
    for (int i = 11; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      prod = 64'(ra) * 64'(rb);
      sum  = 33'(ra) + 33'(rb);
      case (i % 3)
        0:       vecs[i] = mk(2'b00, ra, rb, 32'h0, sum[31:0], sum[32], 1'b0);
        1:       vecs[i] = mk(2'b01, ra, rb, 32'h0, ra - rb, ra < rb, 1'b0);
        default: vecs[i] = mk(2'b10, ra, rb, prod[63:32], prod[31:0], prod[63:32] != 32'h0, 1'b0);
      endcase
    end

    // reset state
    reset   = 1'b1;
    ep_ctrl = 32'h0;
    ep_op_a = 32'h0;
    ep_op_b = 32'h0;
    repeat (3) @(negedge ti_clk);
    chk("reset_status", 64'(ep_status), 64'h0);
    chk("reset_result", {ep_result_hi, ep_result_lo}, 64'h0);
    chk("reset_led",    64'(led_state), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // start re-pulsed and A changed mid-multiply: no restart, original A used
    @(negedge ti_clk);
    ep_ctrl = {28'h0, 1'b0, 2'b10, 1'b0};
    ep_op_a = 32'd3;
    ep_op_b = 32'd5;
    @(negedge ti_clk);
    ep_ctrl[0] = 1'b1;
    @(negedge ti_clk);
    ep_ctrl[0] = 1'b0;
    repeat (9) @(negedge ti_clk);
    ep_ctrl[0] = 1'b1;
    ep_op_a    = 32'd7;
    wait_done("repulse_done");
    exp_count = exp_count + 8'd1;
    chk("repulse_result", {ep_result_hi, ep_result_lo}, 64'd15);
    chk("repulse_count",  64'(ep_status[15:8]), 64'(exp_count));
    seen_busy = 1'b0;
    repeat (40) begin
      @(negedge ti_clk);
      if (ep_status[0]) seen_busy = 1'b1;
    end
    chk("repulse_no_restart", 64'(seen_busy), 64'(1'b0));
    chk("repulse_count_once", 64'(ep_status[15:8]), 64'(exp_count));
    n_vec++;
    $display("repulse: lo=%h status=%h", ep_result_lo, ep_status);

    // clear_done on the completion cycle, then one cycle later
    @(negedge ti_clk);
    ep_ctrl = {28'h0, 1'b0, 2'b00, 1'b0};
    ep_op_a = 32'd1;
    ep_op_b = 32'd2;
    @(negedge ti_clk);
    ep_ctrl[0] = 1'b1;
    @(negedge ti_clk);
    ep_ctrl[3] = 1'b1;
    @(negedge ti_clk);
    exp_count = exp_count + 8'd1;
    chk("clr_same_cycle_done", 64'(ep_status[1]), 64'(1'b1));
    chk("clr_same_cycle_lo",   64'(ep_result_lo), 64'd3);
    @(negedge ti_clk);
    chk("clr_later_done",  64'(ep_status[1]), 64'(1'b0));
    chk("clr_later_lo",    64'(ep_result_lo), 64'd3);
    chk("clr_later_count", 64'(ep_status[15:8]), 64'(exp_count));
    chk("clr_later_led",   64'(led_state), 64'({exp_count[5:0], 2'b00}));
    ep_ctrl[3] = 1'b0;
    n_vec++;
    $display("clear: lo=%h status=%h", ep_result_lo, ep_status);

    // reset mid-multiply with start held high
    @(negedge ti_clk);
    ep_ctrl = {28'h0, 1'b0, 2'b10, 1'b0};
    ep_op_a = 32'hFFFF_FFFF;
    ep_op_b = 32'hFFFF_FFFF;
    @(negedge ti_clk);
    ep_ctrl[0] = 1'b1;
    @(negedge ti_clk);
    repeat (15) @(negedge ti_clk);
    reset = 1'b1;
    #1;
    chk("midreset_status", 64'(ep_status), 64'h0);
    chk("midreset_result", {ep_result_hi, ep_result_lo}, 64'h0);
    @(negedge ti_clk);
    reset = 1'b0;
    exp_count = 8'd0;
    seen_busy = 1'b0;
    repeat (40) begin
      @(negedge ti_clk);
      if (ep_status[1:0] != 2'b00) seen_busy = 1'b1;
    end
    chk("held_start_no_trigger", 64'(seen_busy), 64'(1'b0));
    chk("postreset_status", 64'(ep_status), 64'h0);
    chk("postreset_result", {ep_result_hi, ep_result_lo}, 64'h0);
    chk("postreset_led",    64'(led_state), 64'h0);
    n_vec++;
    $display("midreset: status=%h lo=%h", ep_status, ep_result_lo);
    run_op(mk(2'b00, 32'd2, 32'd3, 32'h0, 32'd5, 1'b0, 1'b0));

    // 256 reserved-op runs from a clean count: wraps back to zero
    @(negedge ti_clk);
    reset = 1'b1;
    ep_ctrl = 32'h0;
    @(negedge ti_clk);
    reset = 1'b0;
    exp_count = 8'd0;
    for (int i = 0; i < 256; i++) run_op(mk(2'b11, $urandom, $urandom, 32'h0, 32'h0, 1'b0, 1'b1));
    chk("wrap_err",   64'(ep_status[3]), 64'(1'b1));
    chk("wrap_count", 64'(ep_status[15:8]), 64'h0);
    chk("wrap_led",   64'(led_state[1:0]), 64'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wire_arith_engine.md
WIRE_ARITH_ENGINE -- requirements
Module: wire_arith_engine

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 8, as the completion-counter width (legal 1..8).
REQ-002 The block SHALL have port ti_clk, input, 1 bit: the single host-interface clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ep_ctrl, input, 32 bits, from wire-in 0x00: [0] start level, [2:1] op, [3] clear_done, others ignored.
REQ-005 The block SHALL have port ep_op_a, input, 32 bits: operand A, from wire-in 0x01.
REQ-006 The block SHALL have port ep_op_b, input, 32 bits: operand B, from wire-in 0x02.
REQ-007 The block SHALL have port ep_result_lo, output, 32 bits: result bits [31:0], to a wire-out.
REQ-008 The block SHALL have port ep_result_hi, output, 32 bits: result bits [63:32], to a wire-out.
REQ-009 The block SHALL have port ep_status, output, 32 bits, to a wire-out: [0] busy, [1] done, [2] flag, [3] err, [8+COUNT_W-1:8] count, all other bits 0.
REQ-010 The block SHALL have port led_state, output, 8 bits, active-high: {count[5:0] zero-extended if COUNT_W<6, done, busy}; the top level applies the open-drain LED inversion.

Function
REQ-011 The block SHALL register ep_ctrl[0] as start_q each cycle; start_edge SHALL be ep_ctrl[0]=1 AND start_q=0.
REQ-012 The FSM SHALL have three states: IDLE, EXEC and MUL.
REQ-013 In IDLE, at the edge where start_edge is sampled (E0), the FSM SHALL latch A, B and op, set busy=1 and clear done, flag and err.
REQ-014 From IDLE, the FSM SHALL go to MUL when op=2'b10 and to EXEC otherwise.
REQ-015 EXEC SHALL last one cycle: results SHALL be written at E0+1, with busy=0, done=1 and count+1, then return to IDLE.
REQ-016 ADD (op 00) SHALL produce lo=A+B mod 2^32, hi=32'h0, and flag=carry out.
REQ-017 SUB (op 01) SHALL produce lo=A-B mod 2^32, hi=32'h0, and flag=borrow (A<B unsigned).
REQ-018 Reserved op 11 SHALL produce lo=hi=0, flag=0 and err=1.
REQ-019 MUL SHALL be an unsigned shift-add over a 64-bit internal accumulator: exactly 32 iterations, one per cycle, at E0+1..E0+32.
REQ-020 At E0+32, MUL SHALL write {hi,lo}=A*B, set flag=(hi!=0), busy=0, done=1 and count+1, and return to IDLE.
REQ-021 ep_result_lo and ep_result_hi SHALL change only at completion and SHALL hold the last result otherwise; there are no partial MUL values on the outputs.
REQ-022 A start_edge while busy SHALL be ignored and not queued; start_q still updates, so a held-high start never retriggers.
REQ-023 done SHALL be sticky until ep_ctrl[3]=1 is sampled or the next start_edge is accepted.
REQ-024 When clear_done and completion fall in the same cycle, completion SHALL win and done=1.
REQ-025 Clear SHALL NOT affect result, flag, err or count.
REQ-026 count SHALL wrap from 2^COUNT_W-1 to 0.
REQ-027 Operand changes on ep_op_a or ep_op_b after E0 SHALL NOT affect the in-flight result.

Reset
REQ-028 While reset=1, asynchronously: FSM=IDLE, all outputs 0, accumulator 0, count 0, start_q=1.
REQ-029 Because start_q resets to 1, a start held high across reset release SHALL NOT trigger; a fresh 0->1 is required.
REQ-030 Reset mid-MUL SHALL abort the operation; outputs SHALL stay 0 and no completion SHALL be reported.

Verification
REQ-031 ADD: A=32'hFFFF_FFFF, B=1, op 00, start 0->1 -> at E0+1: lo=0, hi=0, flag=1, done=1, busy=0, count=1.
REQ-032 SUB: A=5, B=7, op 01 -> lo=32'hFFFF_FFFE, flag=1. Then MUL: A=B=32'hFFFF_FFFF -> busy high exactly 32 cycles; hi=32'hFFFF_FFFE, lo=1, flag=1.
REQ-033 Re-pulse start at cycle E0+10 of a MUL and change A there -> no restart; product uses the original A; count increments once.
REQ-034 Assert clear_done on the completion cycle -> done=1. Assert clear_done one cycle later -> done=0; results and count unchanged.
REQ-035 Assert reset at E0+16 of a MUL with start held high, then release -> all outputs 0 and no operation begins until start goes 0 then 1.
REQ-036 Run 256 op-11 operations with COUNT_W=8 -> err=1, count wraps to 0, led_state[1:0]=2'b10 after the last completion.
